// File: rtl/wb_stage_regfile.sv
// Y86-64 write-back stage: W pipeline register, dstE/dstM decode, 2W/2R register file, sticky halt.
// Optional same-cycle read bypass from the W stage is enabled by defining WB_READ_BYPASS_EN.

module wb_rf_entry #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_e,
   input  logic              we_m,
   input  logic [DATA_W-1:0] d_e,
   input  logic [DATA_W-1:0] d_m,
   output logic [DATA_W-1:0] q
);
   // M port wins so that popq %rsp retires the popped value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (we_m) q <= d_m;
      else if (we_e) q <= d_e;
   end
endmodule

module wb_stage_regfile #(
   parameter int DATA_W     = 64,
   parameter int REG_ADDR_W = 4,
   parameter int NUM_REGS   = 15,
   parameter int RNONE      = 15,
   parameter int RSP_IDX    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_stall,
   input  logic                  w_bubble,
   input  logic [3:0]            m_icode,
   input  logic                  m_cnd,
   input  logic [REG_ADDR_W-1:0] m_rA,
   input  logic [REG_ADDR_W-1:0] m_rB,
   input  logic [DATA_W-1:0]     m_valE,
   input  logic [DATA_W-1:0]     m_valM,
   input  logic [2:0]            m_stat,
   input  logic [REG_ADDR_W-1:0] srcA,
   input  logic [REG_ADDR_W-1:0] srcB,
   output logic [DATA_W-1:0]     valA,
   output logic [DATA_W-1:0]     valB,
   output logic [3:0]            w_icode,
   output logic [REG_ADDR_W-1:0] w_dstE,
   output logic [REG_ADDR_W-1:0] w_dstM,
   output logic [DATA_W-1:0]     w_valE,
   output logic [DATA_W-1:0]     w_valM,
   output logic [2:0]            w_stat,
   output logic                  halted
);
   localparam logic [REG_ADDR_W-1:0] RNONE_A = REG_ADDR_W'(RNONE);
   localparam logic [REG_ADDR_W-1:0] RSP_A   = REG_ADDR_W'(RSP_IDX);
   localparam logic [2:0]            STAT_AOK = 3'd1;

   localparam logic [3:0] I_NOP   = 4'd1;
   localparam logic [3:0] I_CMOV  = 4'd2;
   localparam logic [3:0] I_IRMOV = 4'd3;
   localparam logic [3:0] I_MRMOV = 4'd5;
   localparam logic [3:0] I_OPQ   = 4'd6;
   localparam logic [3:0] I_CALL  = 4'd8;
   localparam logic [3:0] I_RET   = 4'd9;
   localparam logic [3:0] I_PUSH  = 4'd10;
   localparam logic [3:0] I_POP   = 4'd11;

   typedef struct packed {
      logic [3:0]            icode;
      logic                  cnd;
      logic [REG_ADDR_W-1:0] rA;
      logic [REG_ADDR_W-1:0] rB;
      logic [DATA_W-1:0]     valE;
      logic [DATA_W-1:0]     valM;
      logic [2:0]            stat;
   } w_reg_t;

   localparam w_reg_t W_BUBBLE = '{icode: I_NOP, cnd: 1'b0, rA: RNONE_A, rB: RNONE_A,
                                   valE: '0, valM: '0, stat: STAT_AOK};

   w_reg_t w_q;
   w_reg_t m_in;

   assign m_in = '{icode: m_icode, cnd: m_cnd, rA: m_rA, rB: m_rB,
                   valE: m_valE, valM: m_valM, stat: m_stat};

   // Halt freezes W first; stall outranks bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          w_q <= W_BUBBLE;
      else if (halted)     w_q <= w_q;
      else if (w_stall)    w_q <= w_q;
      else if (w_bubble)   w_q <= W_BUBBLE;
      else                 w_q <= m_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     halted <= 1'b0;
      else if (w_q.stat != STAT_AOK)  halted <= 1'b1;
   end

   logic [REG_ADDR_W-1:0] dst_e, dst_m;

   always_comb begin
      dst_e = RNONE_A;
      unique case (w_q.icode)
         I_CMOV:                        dst_e = w_q.cnd ? w_q.rB : RNONE_A;
         I_IRMOV, I_OPQ:                dst_e = w_q.rB;
         I_CALL, I_RET, I_PUSH, I_POP:  dst_e = RSP_A;
         default:                       dst_e = RNONE_A;
      endcase
   end

   always_comb begin
      dst_m = RNONE_A;
      if (w_q.icode == I_MRMOV || w_q.icode == I_POP) dst_m = w_q.rA;
   end

   assign w_icode = w_q.icode;
   assign w_dstE  = dst_e;
   assign w_dstM  = dst_m;
   assign w_valE  = w_q.valE;
   assign w_valM  = w_q.valM;
   assign w_stat  = w_q.stat;

   // Write enables: stage must be live, status AOK, destination implemented.
   logic wr_ok, dst_e_ok, dst_m_ok, we_e, we_m;

   assign wr_ok    = !halted && (w_q.stat == STAT_AOK);
   assign dst_e_ok = (dst_e != RNONE_A) && (32'(dst_e) < NUM_REGS);
   assign dst_m_ok = (dst_m != RNONE_A) && (32'(dst_m) < NUM_REGS);
   assign we_m     = wr_ok && dst_m_ok;
   assign we_e     = wr_ok && dst_e_ok && !(we_m && dst_e == dst_m);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      wb_rf_entry #(.DATA_W(DATA_W)) u_entry (
         .clk   (clk),
         .rst_n (rst_n),
         .we_e  (we_e && dst_e == REG_ADDR_W'(r)),
         .we_m  (we_m && dst_m == REG_ADDR_W'(r)),
         .d_e   (w_q.valE),
         .d_m   (w_q.valM),
         .q     (regs_q[r])
      );
   end

   // Unimplemented and RNONE specifiers simply match no entry and read as 0.
   always_comb begin
      valA = '0;
      valB = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (srcA != RNONE_A && srcA == REG_ADDR_W'(i)) valA = regs_q[i];
         if (srcB != RNONE_A && srcB == REG_ADDR_W'(i)) valB = regs_q[i];
      end
`ifdef WB_READ_BYPASS_EN
      if (we_e && srcA == dst_e) valA = w_q.valE;
      if (we_e && srcB == dst_e) valB = w_q.valE;
      if (we_m && srcA == dst_m) valA = w_q.valM;
      if (we_m && srcB == dst_m) valB = w_q.valM;
`endif
   end

endmodule
